// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared state encoding, command field positions and error byte for reg_bank_burst
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam int         CMD_W      = 8;
    localparam int         CMD_WR_BIT = 7;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;

endpackage

// File: rtl/reg_bank_timer.sv
// rtl/reg_bank_timer.sv - idle counter with clear; expires on the TIMEOUT-th consecutive idle cycle
module reg_bank_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_run && !i_clr && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_run || i_clr || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_burst.sv
// rtl/reg_bank_burst.sv - byte-command register bank with bursts, errors and idle timeout; REG_BANK_ECHO_EN echoes writes on tx
module reg_bank_burst
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int BURST_W = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               err,
    output logic [DEPTH*8-1:0] regs_flat
);

`ifdef REG_BANK_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_regs [DEPTH];
    logic [ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]  r_left;
    logic                r_oor;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_err;

    logic                w_cmd_wr;
    logic [BURST_W-1:0]  w_cmd_len;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic                w_cmd_oor;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_tx_hs;
    logic                w_expire;
    logic                w_load_cmd;
    logic                w_step;
    logic                w_wr_en;
    logic                w_tx_load;
    logic                w_tx_clear;
    logic [7:0]          w_tx_next;
    logic                w_set_err;
    logic                w_clr_err;

    assign w_cmd_wr    = rx_data[CMD_WR_BIT];
    assign w_cmd_len   = rx_data[ADDR_W +: BURST_W];
    assign w_cmd_addr  = rx_data[ADDR_W-1:0];
    assign w_cmd_oor   = (int'(w_cmd_addr) >= DEPTH);
    assign w_addr_next = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
    assign w_tx_hs     = r_tx_valid & tx_ready;

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = (r_state != ST_IDLE);
    assign err      = r_err;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = r_regs[g];
    end

    reg_bank_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (r_state != ST_IDLE),
        .i_clr    (rx_valid | w_tx_hs),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_cmd  = 1'b0;
        w_step      = 1'b0;
        w_wr_en     = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_clear  = 1'b0;
        w_tx_next   = 8'h00;
        w_set_err   = 1'b0;
        w_clr_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    w_load_cmd = 1'b1;
                    w_clr_err  = 1'b1;
                    w_set_err  = w_cmd_oor;
                    if (w_cmd_wr) begin
                        w_state_nxt = w_cmd_oor ? ST_DRAIN : ST_WDATA;
                    end else begin
                        w_state_nxt = ST_RDATA;
                        w_tx_load   = 1'b1;
                        w_tx_next   = w_cmd_oor ? ERR_BYTE : r_regs[w_cmd_addr];
                    end
                end
            end
            ST_WDATA: begin
                if (w_expire) begin
                    w_set_err   = 1'b1;
                    w_tx_clear  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_valid) begin
                    // An echo still waiting for the transmitter blocks the next write byte
                    if (ECHO && r_tx_valid && !tx_ready) begin
                        w_set_err = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        w_step  = 1'b1;
                        if (ECHO) begin
                            w_tx_load = 1'b1;
                            w_tx_next = rx_data;
                        end
                        if (r_left == '0) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_expire) begin
                    w_set_err   = 1'b1;
                    w_tx_clear  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rx_valid) begin
                    w_step = 1'b1;
                    if (r_left == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RDATA: begin
                if (w_expire) begin
                    w_set_err   = 1'b1;
                    w_tx_clear  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_set_err = rx_valid;
                    if (w_tx_hs) begin
                        if (r_left == '0) begin
                            w_tx_clear  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_step    = 1'b1;
                            w_tx_load = 1'b1;
                            w_tx_next = r_oor ? ERR_BYTE : r_regs[w_addr_next];
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_addr     <= '0;
            r_left     <= '0;
            r_oor      <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_load_cmd) begin
                r_addr <= w_cmd_addr;
                r_left <= w_cmd_len;
                r_oor  <= w_cmd_oor;
            end else if (w_step) begin
                r_addr <= w_addr_next;
                r_left <= r_left - 1'b1;
            end
            if (w_wr_en) begin
                r_regs[r_addr] <= rx_data;
            end
            if (w_tx_clear) begin
                r_tx_valid <= 1'b0;
            end else if (w_tx_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_tx_next;
            end else if (w_tx_hs) begin
                r_tx_valid <= 1'b0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (w_clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_burst.sv
// tb/tb_reg_bank_burst.sv - directed self-checking bench for reg_bank_burst (DEPTH 12, TIMEOUT 8)
module tb_reg_bank_burst;

    localparam int DEPTH = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
    logic               busy;
    logic               err;
    logic [DEPTH*8-1:0] regs_flat;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_regs [DEPTH];

    reg_bank_burst #(
        .ADDR_W  (4),
        .BURST_W (3),
        .DEPTH   (DEPTH),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .err       (err),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    function automatic logic [DEPTH*8-1:0] exp_flat();
        logic [DEPTH*8-1:0] f;
        for (int i = 0; i < DEPTH; i++) begin
            f[8*i +: 8] = exp_regs[i];
        end
        return f;
    endfunction

    // Drives one byte across a single rising edge; returns at the following falling edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_regs[i] = 8'h00;
        n_vec++; if (regs_flat !== exp_flat()) begin n_bad++; $display("FAIL reset_regs got %h want %h", regs_flat, exp_flat()); end
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_single_write();
        send(8'h83);
        send(8'h5A);
        exp_regs[3] = 8'h5A;
        n_vec++; if (regs_flat[31:24] !== 8'h5A) begin n_bad++; $display("FAIL single_write got %h want 5a", regs_flat[31:24]); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_write_busy got %b want 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_write_err got %b want 0", err); end
    endtask

    task automatic test_burst_write_wrap();
        send(8'hAB);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        exp_regs[11] = 8'h11;
        exp_regs[0]  = 8'h22;
        exp_regs[1]  = 8'h33;
        n_vec++; if (regs_flat !== exp_flat()) begin n_bad++; $display("FAIL burst_write_wrap got %h want %h", regs_flat, exp_flat()); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_write_busy got %b want 0", busy); end
    endtask

    task automatic test_burst_read_wrap();
        logic [7:0] want [3];
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
        tx_ready = 1'b1;
        send(8'h2B);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (tx_valid !== 1'b1 || tx_data !== want[k]) begin
                n_bad++; $display("FAIL read_wrap_byte%0d got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, want[k]);
            end
            @(negedge clk);
        end
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL read_wrap_end_valid got %b want 0", tx_valid); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_wrap_end_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        send(8'h10);
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
                n_bad++; $display("FAIL backpressure_hold%0d got v=%b d=%h want v=1 d=22", k, tx_valid, tx_data);
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin n_bad++; $display("FAIL backpressure_second got v=%b d=%h want v=1 d=33", tx_valid, tx_data); end
        @(negedge clk);
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL backpressure_end got %b want 0", tx_valid); end
    endtask

    task automatic test_out_of_range();
        tx_ready = 1'b1;
        send(8'h1D);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_read_err got %b want 1", err); end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
                n_bad++; $display("FAIL oor_read_byte%0d got v=%b d=%h want v=1 d=ee", k, tx_valid, tx_data);
            end
            @(negedge clk);
        end
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL oor_read_end got %b want 0", tx_valid); end
        send(8'h9D);
        n_vec++; if (busy !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL oor_write_drain got busy=%b err=%b want 1 1", busy, err); end
        send(8'h01);
        send(8'h02);
        n_vec++; if (regs_flat !== exp_flat()) begin n_bad++; $display("FAIL oor_write_regs got %h want %h", regs_flat, exp_flat()); end
        n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL oor_write_end got err=%b busy=%b want 1 0", err, busy); end
    endtask

    task automatic test_rx_during_read();
        tx_ready = 1'b0;
        send(8'h01);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL cmd_clears_err got %b want 0", err); end
        send(8'h77);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL rx_in_read_err got %b want 1", err); end
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h33 || busy !== 1'b1) begin n_bad++; $display("FAIL rx_in_read_cont got v=%b d=%h busy=%b want 1 33 1", tx_valid, tx_data, busy); end
        tx_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rx_in_read_end got v=%b busy=%b want 0 0", tx_valid, busy); end
    endtask

    task automatic test_timeout();
        send(8'hB0);
        send(8'h44);
        exp_regs[0] = 8'h44;
        repeat (7) @(negedge clk);
        n_vec++; if (busy !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL timeout_early got busy=%b err=%b want 1 0", busy, err); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL timeout_fire got busy=%b err=%b want 0 1", busy, err); end
        n_vec++; if (regs_flat !== exp_flat()) begin n_bad++; $display("FAIL timeout_regs got %h want %h", regs_flat, exp_flat()); end
    endtask

    task automatic test_reset_mid_burst();
        send(8'hF0);
        send(8'hAA);
        send(8'hBB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_regs[i] = 8'h00;
        n_vec++; if (regs_flat !== exp_flat()) begin n_bad++; $display("FAIL midburst_regs got %h want %h", regs_flat, exp_flat()); end
        n_vec++; if (tx_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midburst_state got v=%b busy=%b err=%b want 0 0 0", tx_valid, busy, err); end
    endtask

    task automatic test_echo();
        tx_ready = 1'b0;
        send(8'h81);
        send(8'hA5);
        exp_regs[1] = 8'hA5;
        n_vec++; if (regs_flat !== exp_flat()) begin n_bad++; $display("FAIL echo_regs got %h want %h", regs_flat, exp_flat()); end
`ifdef REG_BANK_ECHO_EN
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin n_bad++; $display("FAIL echo_tx got v=%b d=%h want 1 a5", tx_valid, tx_data); end
        tx_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL echo_done got %b want 0", tx_valid); end
`else
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL no_echo_tx got %b want 0", tx_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write_wrap();
        test_burst_read_wrap();
        test_backpressure();
        test_out_of_range();
        test_rx_during_read();
        test_timeout();
        test_reset_mid_burst();
        test_echo();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
